// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: stage register fields in,
// pipeline steering and performance counters out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ext_freeze;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [4:0]       ex_dst;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic             mem_reg_write;
    logic [4:0]       mem_dst;
    logic             mem_branch;
    logic             mem_zero;
    logic             wb_reg_write;
    logic [4:0]       wb_dst;
    logic             cnt_clr;

    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_flush;
    logic             pc_sel_branch;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] frz_cnt;

    // Pipeline datapath side
    modport master (
        output ext_freeze, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_reg_write,
               ex_dst, ex_rs, ex_rt, mem_reg_write, mem_dst, mem_branch, mem_zero,
               wb_reg_write, wb_dst, cnt_clr,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, pc_sel_branch,
               fwd_a, fwd_b, state_o, stall_cnt, flush_cnt, frz_cnt
    );

    // Hazard controller side
    modport slave (
        input  ext_freeze, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_reg_write,
               ex_dst, ex_rs, ex_rt, mem_reg_write, mem_dst, mem_branch, mem_zero,
               wb_reg_write, wb_dst, cnt_clr,
        output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, pc_sel_branch,
               fwd_a, fwd_b, state_o, stall_cnt, flush_cnt, frz_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: load-use stalls,
// branch-taken flushes, EX operand forwarding, post-reset clear and freeze.
//
//   state | meaning
//   INIT  | pipe held and flushed for INIT_CYC cycles after reset
//   RUN   | normal issue
//   STALL | previous cycle inserted a load-use bubble
//   FLUSH | previous cycle redirected to a taken branch
module pipe_hazard_ctrl #(
    parameter int INIT_CYC = 3,
    parameter int CNT_W    = 16
) (
    input logic              clk,
    input logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] ST_INIT  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_STALL = 2'b10;
    localparam logic [1:0] ST_FLUSH = 2'b11;

    localparam int             IW        = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam logic [IW-1:0]  INIT_LOAD = IW'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IW-1:0]    init_cnt;
    logic             in_init;
    logic             br_tk;
    logic             ld_hz;
    logic             do_frz;
    logic             do_br;
    logic             do_ld;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_flush;
    logic             pc_sel_branch;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] frz_cnt;

    // EX/MEM has the younger result, so it is checked before MEM/WB; r0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       mem_we,
        input logic [4:0] mem_d,
        input logic       wb_we,
        input logic [4:0] wb_d
    );
        if (mem_we && mem_d != 5'd0 && mem_d == src)
            return 2'b10;
        else if (wb_we && wb_d != 5'd0 && wb_d == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && c != CNT_MAX) ? c + 1'b1 : c;
    endfunction

    assign in_init = (state == ST_INIT);
    assign br_tk   = bus.mem_branch & bus.mem_zero;
    assign ld_hz   = bus.ex_mem_read & bus.ex_reg_write & (bus.ex_dst != 5'd0) &
                     ((bus.ex_dst == bus.id_rs) | (bus.id_uses_rt & (bus.ex_dst == bus.id_rt)));

    // A taken branch discards any load-use hazard seen in the same cycle: that instruction is on the wrong path.
    assign do_frz = ~in_init & bus.ext_freeze;
    assign do_br  = ~in_init & ~bus.ext_freeze & br_tk;
    assign do_ld  = ~in_init & ~bus.ext_freeze & ~br_tk & ld_hz;

    // Pipeline steering and next-state decode
    always_comb begin
        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_flush   = 1'b0;
        pc_sel_branch = 1'b0;
        state_nxt     = ST_RUN;
        if (in_init) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            state_nxt   = (init_cnt == '0) ? ST_RUN : ST_INIT;
        end else if (do_frz) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            state_nxt = state;
        end else if (do_br) begin
            pc_sel_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            exmem_flush   = 1'b1;
            state_nxt     = ST_FLUSH;
        end else if (do_ld) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            state_nxt   = ST_STALL;
        end
    end

    // State register and post-reset countdown; freeze does not pause the countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= INIT_LOAD;
        end else begin
            state <= state_nxt;
            if (in_init && init_cnt != '0)
                init_cnt <= init_cnt - 1'b1;
        end
    end

    // Saturating performance counters; clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            frz_cnt   <= '0;
        end else if (bus.cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            frz_cnt   <= '0;
        end else begin
            stall_cnt <= bump(stall_cnt, do_ld);
            flush_cnt <= bump(flush_cnt, do_br);
            frz_cnt   <= bump(frz_cnt, do_frz);
        end
    end

    assign bus.pc_we         = pc_we;
    assign bus.ifid_we       = ifid_we;
    assign bus.ifid_flush    = ifid_flush;
    assign bus.idex_bubble   = idex_bubble;
    assign bus.exmem_flush   = exmem_flush;
    assign bus.pc_sel_branch = pc_sel_branch;
    assign bus.fwd_a   = in_init ? 2'b00 :
                         fwd_sel(bus.ex_rs, bus.mem_reg_write, bus.mem_dst, bus.wb_reg_write, bus.wb_dst);
    assign bus.fwd_b   = in_init ? 2'b00 :
                         fwd_sel(bus.ex_rt, bus.mem_reg_write, bus.mem_dst, bus.wb_reg_write, bus.wb_dst);
    assign bus.state_o   = state;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
    assign bus.frz_cnt   = frz_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: decode table, hand-written
// multi-cycle sequences, and random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int INIT_CYC = 3;

    typedef struct packed {
        logic       frz;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rt;
        logic       ex_mr;
        logic       ex_rw;
        logic [4:0] ex_dst;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic       mem_rw;
        logic [4:0] mem_dst;
        logic       mem_br;
        logic       mem_z;
        logic       wb_rw;
        logic [4:0] wb_dst;
        logic       clr;
    } in_t;

    // ctl = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, pc_sel_branch}
    typedef struct {
        string      name;
        in_t        in;
        logic [5:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
    pipe_hazard_ctrl_if #(.CNT_W(2))  bus2 ();

    pipe_hazard_ctrl #(.INIT_CYC(INIT_CYC), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    pipe_hazard_ctrl #(.INIT_CYC(INIT_CYC), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int     n_chk  = 0;
    int     n_pass = 0;
    in_t    cur;
    vec_t   tbl[$];

    // behavioural model state
    int     init_left;
    int     mst;
    longint c_stall, c_flush, c_frz;
    longint cmax = 65535;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit m_br(input in_t v);
        return v.mem_br && v.mem_z;
    endfunction

    function automatic bit m_ld(input in_t v);
        return v.ex_mr && v.ex_rw && v.ex_dst != 0 &&
               (v.ex_dst == v.id_rs || (v.uses_rt && v.ex_dst == v.id_rt));
    endfunction

    function automatic logic [1:0] m_fwd(input in_t v, input logic [4:0] src);
        if (src == 0) return 2'b00;
        if (v.mem_rw && v.mem_dst == src) return 2'b10;
        if (v.wb_rw && v.wb_dst == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic void model_out(input in_t v, output logic [5:0] ctl,
                                      output logic [1:0] fa, output logic [1:0] fb);
        fa = 2'b00;
        fb = 2'b00;
        if (init_left > 0) begin
            ctl = 6'b001110;
            return;
        end
        fa = m_fwd(v, v.ex_rs);
        fb = m_fwd(v, v.ex_rt);
        if (v.frz)          ctl = 6'b000000;
        else if (m_br(v))   ctl = 6'b111111;
        else if (m_ld(v))   ctl = 6'b000100;
        else                ctl = 6'b110000;
    endfunction

    function automatic longint sat(input longint c);
        return (c < cmax) ? c + 1 : c;
    endfunction

    task automatic model_reset();
        init_left = INIT_CYC;
        mst = 0;
        c_stall = 0;
        c_flush = 0;
        c_frz = 0;
    endtask

    task automatic model_update();
        if (init_left > 0) begin
            init_left--;
            mst = (init_left == 0) ? 1 : 0;
        end else if (cur.frz) begin
            c_frz = sat(c_frz);
        end else if (m_br(cur)) begin
            c_flush = sat(c_flush);
            mst = 3;
        end else if (m_ld(cur)) begin
            c_stall = sat(c_stall);
            mst = 2;
        end else begin
            mst = 1;
        end
        if (cur.clr) begin
            c_stall = 0;
            c_flush = 0;
            c_frz = 0;
        end
    endtask

    function automatic logic [5:0] ctl_act();
        return {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble,
                bus.exmem_flush, bus.pc_sel_branch};
    endfunction

    task automatic check_model(input string tag);
        logic [5:0] ectl;
        logic [1:0] efa, efb;
        model_out(cur, ectl, efa, efb);
        chk({tag, ".ctl"},       ctl_act(),     ectl);
        chk({tag, ".fwd_a"},     bus.fwd_a,     efa);
        chk({tag, ".fwd_b"},     bus.fwd_b,     efb);
        chk({tag, ".state_o"},   bus.state_o,   mst);
        chk({tag, ".stall_cnt"}, bus.stall_cnt, c_stall);
        chk({tag, ".flush_cnt"}, bus.flush_cnt, c_flush);
        chk({tag, ".frz_cnt"},   bus.frz_cnt,   c_frz);
    endtask

    task automatic apply(input in_t v);
        cur = v;
        bus.ext_freeze    = v.frz;
        bus.id_rs         = v.id_rs;
        bus.id_rt         = v.id_rt;
        bus.id_uses_rt    = v.uses_rt;
        bus.ex_mem_read   = v.ex_mr;
        bus.ex_reg_write  = v.ex_rw;
        bus.ex_dst        = v.ex_dst;
        bus.ex_rs         = v.ex_rs;
        bus.ex_rt         = v.ex_rt;
        bus.mem_reg_write = v.mem_rw;
        bus.mem_dst       = v.mem_dst;
        bus.mem_branch    = v.mem_br;
        bus.mem_zero      = v.mem_z;
        bus.wb_reg_write  = v.wb_rw;
        bus.wb_dst        = v.wb_dst;
        bus.cnt_clr       = v.clr;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        apply('0);
        @(negedge clk);
        #1;
        check_model("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input string n, input in_t v, input logic [5:0] ctl,
                       input logic [1:0] fa, input logic [1:0] fb);
        vec_t t;
        t.name = n;
        t.in   = v;
        t.ctl  = ctl;
        t.fa   = fa;
        t.fb   = fb;
        tbl.push_back(t);
    endtask

    function automatic in_t rnd_in();
        in_t v;
        v = '0;
        v.frz     = ($urandom_range(0, 7) == 0);
        v.id_rs   = 5'($urandom_range(0, 7));
        v.id_rt   = 5'($urandom_range(0, 7));
        v.uses_rt = 1'($urandom_range(0, 1));
        v.ex_mr   = 1'($urandom_range(0, 1));
        v.ex_rw   = ($urandom_range(0, 3) != 0);
        v.ex_dst  = 5'($urandom_range(0, 7));
        v.ex_rs   = 5'($urandom_range(0, 7));
        v.ex_rt   = 5'($urandom_range(0, 7));
        v.mem_rw  = 1'($urandom_range(0, 1));
        v.mem_dst = 5'($urandom_range(0, 7));
        v.mem_br  = ($urandom_range(0, 3) == 0);
        v.mem_z   = 1'($urandom_range(0, 1));
        v.wb_rw   = 1'($urandom_range(0, 1));
        v.wb_dst  = 5'($urandom_range(0, 7));
        v.clr     = ($urandom_range(0, 31) == 0);
        return v;
    endfunction

    initial begin
        in_t v;

        bus2.ext_freeze = 0; bus2.id_rs = 0; bus2.id_rt = 0; bus2.id_uses_rt = 0;
        bus2.ex_mem_read = 0; bus2.ex_reg_write = 0; bus2.ex_dst = 0; bus2.ex_rs = 0;
        bus2.ex_rt = 0; bus2.mem_reg_write = 0; bus2.mem_dst = 0; bus2.mem_branch = 0;
        bus2.mem_zero = 0; bus2.wb_reg_write = 0; bus2.wb_dst = 0; bus2.cnt_clr = 0;

        v = '0;                                                            add("idle",       v, 6'b110000, 2'b00, 2'b00);
        v = '0; v.ex_mr = 1; v.ex_rw = 1; v.ex_dst = 2; v.id_rs = 2;       add("ld_rs",      v, 6'b000100, 2'b00, 2'b00);
        v = '0; v.ex_mr = 1; v.ex_rw = 1; v.ex_dst = 7; v.id_rs = 3; v.id_rt = 7; v.uses_rt = 1;
                                                                           add("ld_rt",      v, 6'b000100, 2'b00, 2'b00);
        v.uses_rt = 0;                                                     add("ld_rt_nouse", v, 6'b110000, 2'b00, 2'b00);
        v = '0; v.ex_mr = 1; v.ex_rw = 1; v.ex_dst = 0; v.id_rs = 0;       add("ld_r0",      v, 6'b110000, 2'b00, 2'b00);
        v = '0; v.ex_mr = 1; v.ex_rw = 0; v.ex_dst = 2; v.id_rs = 2;       add("ld_nowr",    v, 6'b110000, 2'b00, 2'b00);
        v = '0; v.mem_br = 1; v.mem_z = 1;                                 add("br",         v, 6'b111111, 2'b00, 2'b00);
        v.ex_mr = 1; v.ex_rw = 1; v.ex_dst = 2; v.id_rs = 2;               add("br_ld",      v, 6'b111111, 2'b00, 2'b00);
        v = '0; v.mem_br = 1; v.mem_z = 0;                                 add("br_nz",      v, 6'b110000, 2'b00, 2'b00);
        v = '0; v.frz = 1; v.mem_br = 1; v.mem_z = 1;                      add("frz_br",     v, 6'b000000, 2'b00, 2'b00);
        v = '0; v.frz = 1; v.ex_mr = 1; v.ex_rw = 1; v.ex_dst = 4; v.id_rs = 4;
                                                                           add("frz_ld",     v, 6'b000000, 2'b00, 2'b00);
        v = '0; v.mem_rw = 1; v.mem_dst = 5; v.wb_rw = 1; v.wb_dst = 5; v.ex_rs = 5;
                                                                           add("fwd_prio",   v, 6'b110000, 2'b10, 2'b00);
        v = '0; v.wb_rw = 1; v.wb_dst = 0; v.ex_rt = 0;                    add("fwd_r0_wb",  v, 6'b110000, 2'b00, 2'b00);
        v = '0; v.mem_rw = 1; v.mem_dst = 0; v.ex_rs = 0;                  add("fwd_r0_mem", v, 6'b110000, 2'b00, 2'b00);
        v = '0; v.wb_rw = 1; v.wb_dst = 9; v.ex_rs = 9; v.ex_rt = 9;       add("fwd_wb",     v, 6'b110000, 2'b01, 2'b01);
        v = '0; v.mem_rw = 0; v.mem_dst = 3; v.wb_rw = 1; v.wb_dst = 3; v.ex_rt = 3;
                                                                           add("fwd_memoff", v, 6'b110000, 2'b00, 2'b01);
        v = '0; v.mem_rw = 1; v.mem_dst = 4; v.ex_rt = 4; v.wb_rw = 1; v.wb_dst = 6; v.ex_rs = 6;
                                                                           add("fwd_mix",    v, 6'b110000, 2'b01, 2'b10);

        // post-reset clear: held for exactly INIT_CYC cycles
        do_reset();
        for (int i = 0; i < INIT_CYC; i++) begin
            #1;
            chk("init.pc_we", bus.pc_we, 0);
            chk("init.ifid_flush", bus.ifid_flush, 1);
            check_model("init");
            tick();
        end
        #1;
        chk("run.pc_we", bus.pc_we, 1);
        chk("run.state_o", bus.state_o, 1);

        // decode table
        foreach (tbl[i]) begin
            apply(tbl[i].in);
            #1;
            chk({tbl[i].name, ".ctl_tbl"}, ctl_act(), tbl[i].ctl);
            chk({tbl[i].name, ".fa_tbl"},  bus.fwd_a, tbl[i].fa);
            chk({tbl[i].name, ".fb_tbl"},  bus.fwd_b, tbl[i].fb);
            check_model(tbl[i].name);
            tick();
        end

        // load-use: one stall cycle, then MEM/WB forwarding
        v = '0; v.clr = 1; apply(v); #1; tick();
        v = '0; v.ex_mr = 1; v.ex_rw = 1; v.ex_dst = 2; v.id_rs = 2; apply(v);
        #1;
        chk("lu.pc_we", bus.pc_we, 0);
        chk("lu.idex_bubble", bus.idex_bubble, 1);
        tick();
        v = '0; v.wb_rw = 1; v.wb_dst = 2; v.ex_rs = 2; apply(v);
        #1;
        chk("lu.fwd_a", bus.fwd_a, 2'b01);
        chk("lu.stall_cnt", bus.stall_cnt, 1);
        chk("lu.state_o", bus.state_o, 2);
        check_model("lu");
        tick();

        // branch taken discards a concurrent load-use hazard
        v = '0; v.clr = 1; apply(v); #1; tick();
        v = '0; v.mem_br = 1; v.mem_z = 1; v.ex_mr = 1; v.ex_rw = 1; v.ex_dst = 2; v.id_rs = 2;
        apply(v);
        #1;
        chk("brld.ctl", ctl_act(), 6'b111111);
        tick();
        apply('0);
        #1;
        chk("brld.flush_cnt", bus.flush_cnt, 1);
        chk("brld.stall_cnt", bus.stall_cnt, 0);
        chk("brld.state_o", bus.state_o, 3);
        tick();

        // freeze held over a taken branch, redirect on release
        v = '0; v.clr = 1; apply(v); #1; tick();
        v = '0; v.frz = 1; v.mem_br = 1; v.mem_z = 1; apply(v);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("frz.pc_sel_branch", bus.pc_sel_branch, 0);
            chk("frz.pc_we", bus.pc_we, 0);
            tick();
        end
        v.frz = 0; apply(v);
        #1;
        chk("frz.release_redirect", bus.pc_sel_branch, 1);
        chk("frz.frz_cnt", bus.frz_cnt, 4);
        check_model("frz");
        tick();

        // saturation and clear priority on the narrow-counter instance
        bus2.ex_mem_read = 1; bus2.ex_reg_write = 1; bus2.ex_dst = 3; bus2.id_rs = 3;
        for (int i = 0; i < 5; i++) begin
            apply('0);
            #1;
            chk("sat.pc_we", bus2.pc_we, 0);
            tick();
        end
        #1;
        chk("sat.stall_cnt", bus2.stall_cnt, 3);
        bus2.cnt_clr = 1;
        #1;
        chk("sat.clr_with_stall", bus2.idex_bubble, 1);
        tick();
        #1;
        chk("sat.cleared", bus2.stall_cnt, 0);
        bus2.cnt_clr = 0; bus2.ex_mem_read = 0;

        // reset in the middle of a stall aborts it and restarts the clear sequence
        v = '0; v.ex_mr = 1; v.ex_rw = 1; v.ex_dst = 6; v.id_rs = 6; apply(v);
        #1;
        chk("midrst.pre_bubble", bus.idex_bubble, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.pc_we", bus.pc_we, 0);
        chk("midrst.ifid_flush", bus.ifid_flush, 1);
        chk("midrst.state_o", bus.state_o, 0);
        check_model("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < INIT_CYC + 2; i++) begin
            #1;
            check_model("midrst_seq");
            tick();
        end

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            apply(rnd_in());
            #1;
            check_model("rnd");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
